// File: rtl/kart_physics_n.sv
// kart_physics_n: per-frame multi-kart physics stepper and race controller.
// Karts are stepped one at a time through a single shared trig ROM port.
module kart_physics_n #(
    parameter int NUM_KARTS    = 2,
    parameter int WORLD        = 2048,
    parameter int MARGIN       = 64,
    parameter int TURN_STEP    = 1,
    parameter int TRIG_LAT     = 2,
    parameter int LAPS_TO_WIN  = 3,
    parameter int COUNT_FRAMES = 180,
    parameter int START_X0     = 100,
    parameter int START_DX     = 200,
    parameter int START_Y      = 100,
    parameter int FIN_Y        = 100,
    parameter int FIN_X_LO     = 64,
    parameter int FIN_X_HI     = 600,
    parameter int HALF_Y       = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       start,
    input  logic                       ext_finish,
    input  logic [NUM_KARTS-1:0]       turn_ccw,
    input  logic [NUM_KARTS-1:0]       turn_cw,
    input  logic [4*NUM_KARTS-1:0]     speed,
    output logic [8:0]                 trig_addr,
    input  logic signed [10:0]         trig_cos,
    input  logic signed [10:0]         trig_sin,
    output logic [11*NUM_KARTS-1:0]    kart_x,
    output logic [11*NUM_KARTS-1:0]    kart_y,
    output logic [9*NUM_KARTS-1:0]     kart_dir,
    output logic [3*NUM_KARTS-1:0]     kart_laps,
    output logic [1:0]                 race_state,
    output logic [2:0]                 winner,
    output logic                       winner_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int KW = (NUM_KARTS > 1) ? $clog2(NUM_KARTS) : 1;
    localparam logic [KW-1:0]      KLAST = KW'(NUM_KARTS - 1);
    localparam logic signed [15:0] CLO   = 16'(MARGIN);
    localparam logic signed [15:0] CHI   = 16'(WORLD - MARGIN);
    localparam logic [10:0]        FY    = 11'(FIN_Y);
    localparam logic [10:0]        FXL   = 11'(FIN_X_LO);
    localparam logic [10:0]        FXH   = 11'(FIN_X_HI);
    localparam logic [10:0]        HY    = 11'(HALF_Y);
    localparam logic [2:0]         LW    = 3'(LAPS_TO_WIN);
    localparam logic [3:0]         WLAST = 4'(TRIG_LAT - 1);

    typedef enum logic [1:0] {R_IDLE, R_CNT, R_RACE, R_DONE} race_t;
    typedef enum logic [2:0] {S_IDLE, S_TURN, S_WAIT, S_MOVE, S_CLAMP} seq_t;

    race_t rs_q, rs_d;
    seq_t  seq_q, seq_d;
    logic [15:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [3:0] w_q, w_d;
    logic [8:0] nd_q, nd_d, ta_q, ta_d;
    logic signed [15:0] dx_q, dx_d, dy_q, dy_d;
    logic [10:0] x_q [NUM_KARTS];
    logic [10:0] x_d [NUM_KARTS];
    logic [10:0] y_q [NUM_KARTS];
    logic [10:0] y_d [NUM_KARTS];
    logic [8:0] dir_q [NUM_KARTS];
    logic [8:0] dir_d [NUM_KARTS];
    logic [2:0] lap_q [NUM_KARTS];
    logic [2:0] lap_d [NUM_KARTS];
    logic [NUM_KARTS-1:0] cp_q, cp_d;
    logic [2:0] win_q, win_d;
    logic wv_q, wv_d, ovr_q, ovr_d;
    logic [3:0] spd [NUM_KARTS];

    logic [8:0] cur;
    logic [9:0] up, dn;
    logic signed [15:0] pc, ps, sx, sy;
    logic [10:0] nx, ny;
    logic lap, won;

    for (genvar g = 0; g < NUM_KARTS; g++) begin : g_k
        assign spd[g] = speed[4*g +: 4];
        assign kart_x[11*g +: 11] = x_q[g];
        assign kart_y[11*g +: 11] = y_q[g];
        assign kart_dir[9*g +: 9] = dir_q[g];
        assign kart_laps[3*g +: 3] = lap_q[g];
    end

    assign trig_addr    = ta_q;
    assign race_state   = rs_q;
    assign winner       = win_q;
    assign winner_valid = wv_q;
    assign busy         = (seq_q != S_IDLE);
    assign overrun      = ovr_q;

    always_comb begin
        rs_d = rs_q;
        seq_d = seq_q;
        cnt_d = cnt_q;
        k_d = k_q;
        w_d = w_q;
        nd_d = nd_q;
        ta_d = ta_q;
        dx_d = dx_q;
        dy_d = dy_q;
        x_d = x_q;
        y_d = y_q;
        dir_d = dir_q;
        lap_d = lap_q;
        cp_d = cp_q;
        win_d = win_q;
        wv_d = wv_q;
        ovr_d = ovr_q | (frame_tick & busy);

        cur = dir_q[k_q];
        up = {1'b0, cur} + 10'(TURN_STEP);
        dn = {1'b0, cur} + 10'(360 - TURN_STEP);
        pc = $signed({12'b0, spd[k_q]}) * $signed(16'(trig_cos));
        ps = $signed({12'b0, spd[k_q]}) * $signed(16'(trig_sin));
        sx = $signed({5'b0, x_q[k_q]}) + dx_q;
        sy = $signed({5'b0, y_q[k_q]}) + dy_q;
        nx = (sx < CLO) ? 11'(CLO) : (sx > CHI) ? 11'(CHI) : 11'(sx);
        ny = (sy < CLO) ? 11'(CLO) : (sy > CHI) ? 11'(CHI) : 11'(sy);
        lap = cp_q[k_q] && (y_q[k_q] > FY) && (ny <= FY)
              && (nx >= FXL) && (nx <= FXH);
        won = lap && ((lap_q[k_q] + 3'd1) == LW);

        case (rs_q)
            R_IDLE: if (start) begin
                rs_d = R_CNT;
                cnt_d = 16'(COUNT_FRAMES);
            end
            R_CNT: if (frame_tick) begin
                if (cnt_q <= 16'd1) begin
                    rs_d = R_RACE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            R_RACE: if (ext_finish) rs_d = R_DONE;
            default: ;
        endcase

        case (seq_q)
            S_IDLE: if (rs_q == R_RACE && frame_tick) begin
                seq_d = S_TURN;
                k_d = '0;
            end
            S_TURN: begin
                nd_d = cur;
                if (turn_ccw[k_q] && !turn_cw[k_q])
                    nd_d = (up >= 10'd360) ? 9'(up - 10'd360) : up[8:0];
                else if (turn_cw[k_q] && !turn_ccw[k_q])
                    nd_d = (dn >= 10'd360) ? 9'(dn - 10'd360) : dn[8:0];
                ta_d = nd_d;
                w_d = '0;
                seq_d = (TRIG_LAT == 0) ? S_MOVE : S_WAIT;
            end
            S_WAIT: begin
                if (w_q == WLAST) seq_d = S_MOVE;
                else w_d = w_q + 4'd1;
            end
            S_MOVE: begin
                dx_d = pc >>> 9;
                dy_d = -(ps >>> 9);
                seq_d = S_CLAMP;
            end
            S_CLAMP: begin
                x_d[k_q] = nx;
                y_d[k_q] = ny;
                dir_d[k_q] = nd_q;
                if (lap) begin
                    lap_d[k_q] = lap_q[k_q] + 3'd1;
                    cp_d[k_q] = 1'b0;
                end else if (ny > HY) begin
                    cp_d[k_q] = 1'b1;
                end
                // a winner ends the frame: later karts keep their old state
                if (won) begin
                    rs_d = R_DONE;
                    win_d = 3'(k_q);
                    wv_d = 1'b1;
                    seq_d = S_IDLE;
                end else if (k_q == KLAST) begin
                    seq_d = S_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                    seq_d = S_TURN;
                end
            end
            default: seq_d = S_IDLE;
        endcase

        if (rs_q == R_RACE && ext_finish) seq_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_q <= R_IDLE;
            seq_q <= S_IDLE;
            cnt_q <= '0;
            k_q <= '0;
            w_q <= '0;
            nd_q <= '0;
            ta_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            for (int k = 0; k < NUM_KARTS; k++) begin
                x_q[k] <= 11'(START_X0 + k * START_DX);
                y_q[k] <= 11'(START_Y);
                dir_q[k] <= 9'd90;
                lap_q[k] <= '0;
            end
            cp_q <= '0;
            win_q <= '0;
            wv_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            rs_q <= rs_d;
            seq_q <= seq_d;
            cnt_q <= cnt_d;
            k_q <= k_d;
            w_q <= w_d;
            nd_q <= nd_d;
            ta_q <= ta_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            x_q <= x_d;
            y_q <= y_d;
            dir_q <= dir_d;
            lap_q <= lap_d;
            cp_q <= cp_d;
            win_q <= win_d;
            wv_q <= wv_d;
            ovr_q <= ovr_d;
        end
    end

endmodule

// File: tb/tb_kart_physics_n.sv
// Bench for kart_physics_n: frame results are queued as expectations and
// checked by a monitor each time the step sequencer drops busy.
module tb_kart_physics_n;

    logic clk = 1'b0;
    logic rst;
    logic frame_tick, start, ext_finish;
    logic [1:0] turn_ccw, turn_cw;
    logic [7:0] speed;
    logic [8:0] trig_addr;
    logic signed [10:0] trig_cos, trig_sin;
    logic [21:0] kart_x, kart_y;
    logic [17:0] kart_dir;
    logic [5:0] kart_laps;
    logic [1:0] race_state;
    logic [2:0] winner;
    logic winner_valid, busy, overrun;

    kart_physics_n #(.NUM_KARTS(2), .COUNT_FRAMES(3)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
        .ext_finish(ext_finish), .turn_ccw(turn_ccw), .turn_cw(turn_cw),
        .speed(speed), .trig_addr(trig_addr), .trig_cos(trig_cos),
        .trig_sin(trig_sin), .kart_x(kart_x), .kart_y(kart_y),
        .kart_dir(kart_dir), .kart_laps(kart_laps),
        .race_state(race_state), .winner(winner),
        .winner_valid(winner_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // two-cycle cos/sin ROM covering the cardinal headings
    function automatic logic [21:0] rom(input logic [8:0] a);
        case (a)
            9'd0:    rom = {11'd512, 11'd0};
            9'd90:   rom = {11'd0, 11'd512};
            9'd180:  rom = {11'h600, 11'd0};
            9'd270:  rom = {11'd0, 11'h600};
            default: rom = 22'd0;
        endcase
    endfunction

    logic [21:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= rom(trig_addr);
        p2 <= p1;
    end
    assign trig_cos = p2[21:11];
    assign trig_sin = p2[10:0];

    typedef struct {
        logic [21:0] x;
        logic [21:0] y;
        logic [17:0] dir;
        logic [5:0]  laps;
        logic [1:0]  rs;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int last_busy;
    int ex_x[2], ex_y[2], ex_dir[2], ex_lap[2], ex_rs;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    logic bprev = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            bprev = 1'b0;
        end else begin
            if (bprev && !busy) begin
                if (q.size() == 0) begin
                    chk("unexpected_step", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("kart_x", 32'(kart_x), 32'(e.x));
                    chk("kart_y", 32'(kart_y), 32'(e.y));
                    chk("kart_dir", 32'(kart_dir), 32'(e.dir));
                    chk("kart_laps", 32'(kart_laps), 32'(e.laps));
                    chk("race_state", 32'(race_state), 32'(e.rs));
                end
            end
            bprev = busy;
        end
    end

    task automatic set_reset_exp();
        ex_x[0] = 100; ex_x[1] = 300;
        ex_y[0] = 100; ex_y[1] = 100;
        ex_dir[0] = 90; ex_dir[1] = 90;
        ex_lap[0] = 0; ex_lap[1] = 0;
        ex_rs = 0;
    endtask

    task automatic tick();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
    endtask

    task automatic run(input logic [1:0] ccw, input logic [1:0] cw,
                       input logic [7:0] spd, input bit extra);
        exp_t e;
        e.x = {11'(ex_x[1]), 11'(ex_x[0])};
        e.y = {11'(ex_y[1]), 11'(ex_y[0])};
        e.dir = {9'(ex_dir[1]), 9'(ex_dir[0])};
        e.laps = {3'(ex_lap[1]), 3'(ex_lap[0])};
        e.rs = 2'(ex_rs);
        q.push_back(e);
        turn_ccw = ccw;
        turn_cw = cw;
        speed = spd;
        tick();
        last_busy = 0;
        for (int i = 0; i < 64 && busy; i++) begin
            last_busy++;
            frame_tick = extra && (i == 2);
            @(negedge clk);
        end
        frame_tick = 1'b0;
        chk("step_started", 32'(last_busy != 0), 32'd1);
        chk("step_ended", 32'(busy), 32'd0);
    endtask

    task automatic turn_n(input int n, input logic [1:0] ccw,
                          input logic [1:0] cw);
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (ccw[k] && !cw[k]) ex_dir[k] = (ex_dir[k] + 1) % 360;
                else if (cw[k] && !ccw[k]) ex_dir[k] = (ex_dir[k] + 359) % 360;
            end
            run(ccw, cw, 8'h00, 1'b0);
        end
    endtask

    task automatic move_n(input int n, input logic [7:0] spd,
                          input int dx0, input int dy0,
                          input int dx1, input int dy1);
        for (int i = 0; i < n; i++) begin
            ex_x[0] += dx0; ex_y[0] += dy0;
            ex_x[1] += dx1; ex_y[1] += dy1;
            run(2'b00, 2'b00, spd, 1'b0);
        end
    endtask

    task automatic countdown();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("cd_state", 32'(race_state), 32'd1);
        tick();
        chk("cd_tick1", 32'(race_state), 32'd1);
        tick();
        chk("cd_tick2", 32'(race_state), 32'd1);
        tick();
        chk("cd_tick3", 32'(race_state), 32'd2);
        chk("cd_x", 32'(kart_x), {10'd0, 11'd300, 11'd100});
        chk("cd_y", 32'(kart_y), {10'd0, 11'd100, 11'd100});
        chk("cd_busy", 32'(busy), 32'd0);
        ex_rs = 2;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        frame_tick = 1'b0; start = 1'b0; ext_finish = 1'b0;
        turn_ccw = '0; turn_cw = '0; speed = '0;
        set_reset_exp();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_x", 32'(kart_x), {10'd0, 11'd300, 11'd100});
        chk("rst_y", 32'(kart_y), {10'd0, 11'd100, 11'd100});
        chk("rst_dir", 32'(kart_dir), {14'd0, 9'd90, 9'd90});
        chk("rst_laps", 32'(kart_laps), 32'd0);
        chk("rst_state", 32'(race_state), 32'd0);
        chk("rst_flags", {27'd0, winner_valid, busy, overrun, 2'b0},
            32'd0);
        chk("rst_winner", 32'(winner), 32'd0);
        chk("rst_trig", 32'(trig_addr), 32'd0);

        countdown();

        turn_n(90, 2'b00, 2'b11);
        chk("busy_cycles", 32'(last_busy), 32'd10);
        ex_x[0] += 6;
        run(2'b00, 2'b00, 8'h06, 1'b0);
        move_n(112, 8'hF0, 0, 0, 15, 0);
        ex_x[1] = 1984;
        run(2'b00, 2'b00, 8'h60, 1'b0);
        turn_n(1, 2'b00, 2'b01);
        chk("wrap_cw", 32'(kart_dir[8:0]), 32'd359);
        turn_n(1, 2'b01, 2'b01);
        turn_n(1, 2'b01, 2'b00);
        chk("wrap_ccw", 32'(kart_dir[8:0]), 32'd0);
        turn_n(90, 2'b01, 2'b00);
        ex_y[0] = 85; run(2'b00, 2'b00, 8'h0F, 1'b0);
        ex_y[0] = 70; run(2'b00, 2'b00, 8'h0F, 1'b0);
        ex_y[0] = 64; run(2'b00, 2'b00, 8'h0F, 1'b0);
        run(2'b00, 2'b00, 8'h0F, 1'b0);
        chk("pre_overrun", 32'(overrun), 32'd0);
        ex_dir[0] = 91;
        run(2'b01, 2'b00, 8'h00, 1'b1);
        chk("overrun", 32'(overrun), 32'd1);
        @(negedge clk) ext_finish = 1'b1;
        @(negedge clk) ext_finish = 1'b0;
        chk("ext_state", 32'(race_state), 32'd3);
        chk("ext_wv", 32'(winner_valid), 32'd0);
        tick();
        chk("done_no_step", 32'(busy), 32'd0);

        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("rst2_state", 32'(race_state), 32'd0);
        chk("rst2_overrun", 32'(overrun), 32'd0);
        chk("rst2_x", 32'(kart_x), {10'd0, 11'd300, 11'd100});
        rst = 1'b1;
        set_reset_exp();
        countdown();
        turn_n(180, 2'b11, 2'b00);
        for (int lap = 1; lap <= 3; lap++) begin
            move_n(62, 8'hFF, 0, 15, 0, 15);
            turn_n(180, 2'b11, 2'b00);
            move_n(61, 8'hFF, 0, -15, 0, -15);
            ex_y[0] = 100;
            ex_lap[0] = lap;
            if (lap < 3) begin
                ex_y[1] = 100;
                ex_lap[1] = lap;
                run(2'b00, 2'b00, 8'hFF, 1'b0);
                chk("lap_wv", 32'(winner_valid), 32'd0);
                turn_n(180, 2'b11, 2'b00);
            end else begin
                ex_rs = 3;
                run(2'b00, 2'b00, 8'hFF, 1'b0);
                chk("win_busy", 32'(last_busy), 32'd5);
                chk("winner", 32'(winner), 32'd0);
                chk("winner_valid", 32'(winner_valid), 32'd1);
            end
        end
        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
